// File: rtl/cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl
//   Miss-handling FSM between the data cache and main memory. On a cacheable
//   miss it writes back the dirty victim line (if any), fetches the missing
//   line one word per req/ack beat, then pulses update so the cache installs
//   it. stall holds the CPU for the whole sequence; I/O accesses bypass it.
//
//   Optional feature macro: CACHE_MISS_STATS_EN adds saturating miss and
//   writeback counters (stat_miss, stat_wb).
//
// Ports
//   CLK, RESET_N          clock (posedge), asynchronous active-low reset
//   addr                  CPU byte address of the current access
//   MEM_READ2/MEM_WRITE2  CPU load / store request
//   hit, miss             cache lookup result (combinational)
//   addr_is_io            access is memory-mapped I/O; no cache action
//   evict, evicted_addr   victim dirty flag + line address (valid in CHK)
//   w0_out..w3_out        victim line words (valid with evict)
//   w0_in..w3_in          fill line words to cache, held until next fill
//   update                one-cycle install pulse
//   stall                 CPU hold while a miss is serviced
//   mem_req/mem_we        memory beat request / 1 = write beat
//   mem_addr/mem_wdata    word-aligned beat address / write data
//   mem_ack/mem_rdata     beat accept / read data
//   stat_miss, stat_wb    (CACHE_MISS_STATS_EN only) event counters
// ---------------------------------------------------------------------------
module cache_miss_ctrl #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] addr,
    input  logic              MEM_READ2,
    input  logic              MEM_WRITE2,
    input  logic              hit,
    input  logic              miss,
    input  logic              addr_is_io,
    input  logic              evict,
    input  logic [ADDR_W-1:0] evicted_addr,
    input  logic [DATA_W-1:0] w0_out,
    input  logic [DATA_W-1:0] w1_out,
    input  logic [DATA_W-1:0] w2_out,
    input  logic [DATA_W-1:0] w3_out,
    output logic [DATA_W-1:0] w0_in,
    output logic [DATA_W-1:0] w1_in,
    output logic [DATA_W-1:0] w2_in,
    output logic [DATA_W-1:0] w3_in,
    output logic              update,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_MISS_STATS_EN
    ,
    output logic [31:0]       stat_miss,
    output logic [31:0]       stat_wb
`endif
);

    localparam int unsigned BEAT_W     = $clog2(WORDS_PER_LINE);
    localparam int unsigned WORD_SHIFT = $clog2(DATA_W / 8);
    localparam int unsigned LINE_BYTES = WORDS_PER_LINE * (DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_BYTES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_WB, S_FILL, S_UPDATE, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] victim_base;
    logic [ADDR_W-1:0] beat_off;
    logic [DATA_W-1:0] wb_buf   [WORDS_PER_LINE];
    logic [DATA_W-1:0] fill_buf [WORDS_PER_LINE];
    logic              start;
    logic              unused_hit;

    // The cache's miss flag already excludes hits; hit is kept for port compatibility.
    assign unused_hit = hit;

    assign start    = miss & (MEM_READ2 | MEM_WRITE2) & ~addr_is_io;
    assign beat_off = ADDR_W'(beat) << WORD_SHIFT;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Datapath registers: line address, victim buffer, fill buffer, beat counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            beat        <= '0;
            line_addr   <= '0;
            victim_base <= '0;
            for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
                wb_buf[i]   <= '0;
                fill_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (start) line_addr <= addr & ~OFF_MASK;
                S_CHK: begin
                    if (evict) begin
                        victim_base <= evicted_addr & ~OFF_MASK;
                        wb_buf[0]   <= w0_out;
                        wb_buf[1]   <= w1_out;
                        wb_buf[2]   <= w2_out;
                        wb_buf[3]   <= w3_out;
                    end
                end
                S_WB: begin
                    if (mem_ack) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                end
                S_FILL: begin
                    if (mem_ack) begin
                        fill_buf[beat] <= mem_rdata;
                        beat           <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CHK;
            S_CHK:    state_nxt = evict ? S_WB : S_FILL;
            S_WB:     if (mem_ack && beat == LAST_BEAT) state_nxt = S_FILL;
            S_FILL:   if (mem_ack && beat == LAST_BEAT) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from state only, so reset drops mem_req asynchronously
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        update    = 1'b0;
        stall     = (state != S_IDLE) | start;
        case (state)
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_base + beat_off;
                mem_wdata = wb_buf[beat];
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = line_addr + beat_off;
            end
            S_UPDATE: update = 1'b1;
            default: ;
        endcase
    end

    assign w0_in = fill_buf[0];
    assign w1_in = fill_buf[1];
    assign w2_in = fill_buf[2];
    assign w3_in = fill_buf[3];

`ifdef CACHE_MISS_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_miss <= '0;
            stat_wb   <= '0;
        end else begin
            if (state == S_IDLE && start && stat_miss != '1) stat_miss <= stat_miss + 1'b1;
            if (state == S_CHK && evict && stat_wb != '1)    stat_wb   <= stat_wb + 1'b1;
        end
    end
`endif

endmodule
